// File: rtl/adc_sequencer.sv
// Arbitrates the MAX10 ADC command/response interface between a periodic primary
// requester and a CPU stb/ack requester, one conversion in flight at a time.
module adc_sequencer #(
   parameter int unsigned PRIM_CHANNEL = 1,
   parameter int unsigned MAX_PRIM_RUN = 4,
   parameter int unsigned TIMEOUT      = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        prim_req,
   output logic [11:0] prim_data,
   output logic        prim_stb,
   input  logic [31:0] in,
   input  logic        in_stb,
   output logic        in_ack,
   output logic [31:0] out,
   output logic        out_stb,
   input  logic        out_ack,
   output logic        command_valid,
   output logic [4:0]  command_channel,
   output logic        command_startofpacket,
   output logic        command_endofpacket,
   input  logic        command_ready,
   input  logic        response_valid,
   input  logic [4:0]  response_channel,
   input  logic [11:0] response_data,
   input  logic        status_clr,
   output logic [31:0] status
);

   localparam int unsigned TW = $clog2(TIMEOUT + 2);
   localparam int unsigned RW = $clog2(MAX_PRIM_RUN + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WAIT,
      S_DELIVER,
      S_ABORT
   } state_t;

   state_t          state_q,        state_d;
   logic [TW-1:0]   timer_q,        timer_d;
   logic [RW-1:0]   run_q,          run_d;
   logic            prim_pending_q, prim_pending_d;
   logic            sec_pending_q,  sec_pending_d;
   logic [4:0]      sec_chan_q,     sec_chan_d;
   logic            sel_sec_q,      sel_sec_d;
   logic            cmd_valid_q,    cmd_valid_d;
   logic [4:0]      cmd_chan_q,     cmd_chan_d;
   logic [11:0]     prim_data_q,    prim_data_d;
   logic            prim_stb_q,     prim_stb_d;
   logic            in_ack_q,       in_ack_d;
   logic [31:0]     out_q,          out_d;
   logic            out_stb_q,      out_stb_d;
   logic [7:0]      ovr_q,          ovr_d;
   logic [7:0]      tmo_q,          tmo_d;
   logic [7:0]      mis_q,          mis_d;
   logic [31:0]     status_q,       status_d;
   logic            prim_inflight;
   logic            unused_in;

   assign unused_in = ^in[31:5];

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      run_d          = run_q;
      prim_pending_d = prim_pending_q;
      sec_pending_d  = sec_pending_q;
      sec_chan_d     = sec_chan_q;
      sel_sec_d      = sel_sec_q;
      cmd_valid_d    = cmd_valid_q;
      cmd_chan_d     = cmd_chan_q;
      prim_data_d    = prim_data_q;
      prim_stb_d     = 1'b0;
      in_ack_d       = 1'b0;
      out_d          = out_q;
      out_stb_d      = out_stb_q;
      ovr_d          = ovr_q;
      tmo_d          = tmo_q;
      mis_d          = mis_q;

      // A primary request during an undelivered primary merges into it and counts as overrun
      prim_inflight = ((state_q == S_CMD) || (state_q == S_WAIT)) && !sel_sec_q;
      if (prim_req) begin
         if (prim_pending_q || prim_inflight) ovr_d = sat_inc(ovr_q);
         else                                 prim_pending_d = 1'b1;
      end

      if (in_stb && !sec_pending_q && !out_stb_q) begin
         in_ack_d      = 1'b1;
         sec_pending_d = 1'b1;
         sec_chan_d    = in[4:0];
      end

      if (out_stb_q && out_ack) out_stb_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sec_pending_q && (!prim_pending_q || (run_q == RW'(MAX_PRIM_RUN)))) begin
               sec_pending_d = 1'b0;
               run_d         = '0;
               sel_sec_d     = 1'b1;
               cmd_chan_d    = sec_chan_q;
               cmd_valid_d   = 1'b1;
               state_d       = S_CMD;
            end else if (prim_pending_q) begin
               prim_pending_d = 1'b0;
               if (sec_pending_q && (run_q != RW'(MAX_PRIM_RUN))) run_d = run_q + RW'(1);
               sel_sec_d      = 1'b0;
               cmd_chan_d     = 5'(PRIM_CHANNEL);
               cmd_valid_d    = 1'b1;
               state_d        = S_CMD;
            end
         end
         S_CMD: begin
            if (command_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_WAIT;
            end else if (timer_q == TW'(TIMEOUT)) begin
               cmd_valid_d = 1'b0;
               state_d     = S_ABORT;
            end
         end
         S_WAIT: begin
            if (response_valid && (response_channel == cmd_chan_q)) begin
               if (sel_sec_q) begin
                  out_d     = {1'b0, 10'd0, cmd_chan_q, 4'd0, response_data};
                  out_stb_d = 1'b1;
               end else begin
                  prim_data_d = response_data;
                  prim_stb_d  = 1'b1;
               end
               state_d = S_DELIVER;
            end else begin
               if (response_valid) mis_d = sat_inc(mis_q);
               if (timer_q == TW'(TIMEOUT)) state_d = S_ABORT;
            end
         end
         S_DELIVER: state_d = S_IDLE;
         S_ABORT: begin
            tmo_d = sat_inc(tmo_q);
            if (sel_sec_q) begin
               out_d     = {1'b1, 10'd0, cmd_chan_q, 16'd0};
               out_stb_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)                            timer_d = '0;
      else if ((state_q == S_CMD) || (state_q == S_WAIT)) timer_d = timer_q + TW'(1);

      if (status_clr) begin
         ovr_d = '0;
         tmo_d = '0;
         mis_d = '0;
      end

      status_d = {7'd0, (state_d != S_IDLE), mis_d, tmo_d, ovr_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         run_q          <= '0;
         prim_pending_q <= 1'b0;
         sec_pending_q  <= 1'b0;
         sec_chan_q     <= '0;
         sel_sec_q      <= 1'b0;
         cmd_valid_q    <= 1'b0;
         cmd_chan_q     <= '0;
         prim_data_q    <= '0;
         prim_stb_q     <= 1'b0;
         in_ack_q       <= 1'b0;
         out_q          <= '0;
         out_stb_q      <= 1'b0;
         ovr_q          <= '0;
         tmo_q          <= '0;
         mis_q          <= '0;
         status_q       <= '0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         run_q          <= run_d;
         prim_pending_q <= prim_pending_d;
         sec_pending_q  <= sec_pending_d;
         sec_chan_q     <= sec_chan_d;
         sel_sec_q      <= sel_sec_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_chan_q     <= cmd_chan_d;
         prim_data_q    <= prim_data_d;
         prim_stb_q     <= prim_stb_d;
         in_ack_q       <= in_ack_d;
         out_q          <= out_d;
         out_stb_q      <= out_stb_d;
         ovr_q          <= ovr_d;
         tmo_q          <= tmo_d;
         mis_q          <= mis_d;
         status_q       <= status_d;
      end
   end

   assign prim_data             = prim_data_q;
   assign prim_stb              = prim_stb_q;
   assign in_ack                = in_ack_q;
   assign out                   = out_q;
   assign out_stb               = out_stb_q;
   assign command_valid         = cmd_valid_q;
   assign command_channel       = cmd_chan_q;
   assign command_startofpacket = cmd_valid_q;
   assign command_endofpacket   = cmd_valid_q;
   assign status                = status_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: hand-driven ADC responses plus a simple
// auto-responding ADC model for the arbitration run.
module tb_adc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        prim_req;
   logic [11:0] prim_data;
   logic        prim_stb;
   logic [31:0] in;
   logic        in_stb;
   logic        in_ack;
   logic [31:0] out;
   logic        out_stb;
   logic        out_ack;
   logic        command_valid;
   logic [4:0]  command_channel;
   logic        command_startofpacket;
   logic        command_endofpacket;
   logic        command_ready;
   logic        response_valid;
   logic [4:0]  response_channel;
   logic [11:0] response_data;
   logic        status_clr;
   logic [31:0] status;

   adc_sequencer #(.PRIM_CHANNEL(1), .MAX_PRIM_RUN(4), .TIMEOUT(1023)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .prim_req             (prim_req),
      .prim_data            (prim_data),
      .prim_stb             (prim_stb),
      .in                   (in),
      .in_stb               (in_stb),
      .in_ack               (in_ack),
      .out                  (out),
      .out_stb              (out_stb),
      .out_ack              (out_ack),
      .command_valid        (command_valid),
      .command_channel      (command_channel),
      .command_startofpacket(command_startofpacket),
      .command_endofpacket  (command_endofpacket),
      .command_ready        (command_ready),
      .response_valid       (response_valid),
      .response_channel     (response_channel),
      .response_data        (response_data),
      .status_clr           (status_clr),
      .status               (status)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic       adc_auto = 1'b0;
   int         resp_cnt = 0;
   logic [4:0] resp_ch  = '0;
   logic [4:0] chan_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] adc_val(input logic [4:0] ch);
      return {ch[3:0], ch[3:0], ch[3:0]};
   endfunction

   // Advance one cycle; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (adc_auto) begin
         response_valid = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               response_valid   = 1'b1;
               response_channel = resp_ch;
               response_data    = adc_val(resp_ch);
            end
         end
         if (command_valid && command_ready) begin
            chan_log.push_back(command_channel);
            resp_ch  = command_channel;
            resp_cnt = 3;
         end
      end
   endtask

   task automatic wait_cmd(input string tag);
      int n = 0;
      while (!command_valid && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(command_valid), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n_prim;
      int n_out;
      int guard;
      int n_cmd;
      logic [31:0] out_val;
      logic [4:0]  exp_seq[6];

      rst = 1'b1; prim_req = 1'b0; in = '0; in_stb = 1'b0; out_ack = 1'b0;
      command_ready = 1'b0; response_valid = 1'b0; response_channel = '0;
      response_data = '0; status_clr = 1'b0;
      do_reset();

      check("rst_prim_stb", 32'(prim_stb), 32'd0);
      check("rst_prim_data", 32'(prim_data), 32'd0);
      check("rst_in_ack", 32'(in_ack), 32'd0);
      check("rst_out", out, 32'd0);
      check("rst_out_stb", 32'(out_stb), 32'd0);
      check("rst_cmd", {29'd0, command_valid, command_startofpacket, command_endofpacket}, 32'd0);
      check("rst_status", status, 32'd0);

      // Primary conversion latency
      prim_req = 1'b1; tick(); prim_req = 1'b0;
      check("t1_cmd_n1", 32'(command_valid), 32'd0);
      tick();
      check("t1_cmd_n2", {26'd0, command_valid, command_channel}, {26'd0, 1'b1, 5'd1});
      check("t1_sop_eop", {30'd0, command_startofpacket, command_endofpacket}, 32'd3);
      check("t1_busy", 32'(status[24]), 32'd1);
      command_ready = 1'b1; tick(); command_ready = 1'b0;
      check("t1_cmd_drop", 32'(command_valid), 32'd0);
      tick(); tick();
      response_valid = 1'b1; response_channel = 5'd1; response_data = 12'hABC;
      tick(); response_valid = 1'b0;
      check("t1_prim_stb", {19'd0, prim_stb, prim_data}, {19'd0, 1'b1, 12'hABC});
      tick();
      check("t1_prim_stb_1cyc", 32'(prim_stb), 32'd0);
      check("t1_idle", 32'(status[24]), 32'd0);

      // Secondary read with stb/ack
      in = 32'h0000_0005; in_stb = 1'b1; tick();
      check("t2_in_ack", 32'(in_ack), 32'd1);
      in_stb = 1'b0; tick();
      check("t2_in_ack_pulse", 32'(in_ack), 32'd0);
      wait_cmd("t2_cmd_wait");
      check("t2_cmd_ch", 32'(command_channel), 32'd5);
      command_ready = 1'b1; tick(); command_ready = 1'b0;
      tick();
      response_valid = 1'b1; response_channel = 5'd5; response_data = 12'h123;
      tick(); response_valid = 1'b0;
      check("t2_out", out, 32'h0005_0123);
      check("t2_out_stb", 32'(out_stb), 32'd1);
      tick(); tick(); tick();
      check("t2_out_stb_held", 32'(out_stb), 32'd1);
      in = 32'h0000_0006; in_stb = 1'b1; tick();
      check("t2_no_ack_while_out", 32'(in_ack), 32'd0);
      in_stb = 1'b0;
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      check("t2_out_stb_drop", 32'(out_stb), 32'd0);

      // Primary run bound with a waiting secondary
      do_reset();
      adc_auto = 1'b1; command_ready = 1'b1; resp_cnt = 0; chan_log.delete();
      prim_req = 1'b1; in = 32'h0000_0003; in_stb = 1'b1; tick(); prim_req = 1'b0;
      check("t3_in_ack", 32'(in_ack), 32'd1);
      in_stb = 1'b0;
      n_prim = 0; n_out = 0; guard = 0; out_val = '0;
      while ((n_prim < 5 || n_out < 1) && guard < 400) begin
         tick();
         guard++;
         prim_req = 1'b0;
         out_ack  = 1'b0;
         if (prim_stb) begin
            n_prim++;
            if (n_prim <= 4) prim_req = 1'b1;
         end
         if (out_stb) begin
            n_out++;
            out_val = out;
            out_ack = 1'b1;
         end
      end
      prim_req = 1'b0; out_ack = 1'b0;
      check("t3_done_in_time", 32'(guard < 400), 32'd1);
      check("t3_num_cmds", 32'(chan_log.size()), 32'd6);
      exp_seq = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd3, 5'd1};
      for (int i = 0; i < 6; i++)
         if (i < chan_log.size()) check($sformatf("t3_seq%0d", i), 32'(chan_log[i]), 32'(exp_seq[i]));
      check("t3_out", out_val, 32'h0003_0333);
      adc_auto = 1'b0; command_ready = 1'b0; response_valid = 1'b0;
      tick(); tick(); tick(); tick();

      // Overrun while a primary is outstanding
      do_reset();
      prim_req = 1'b1; tick(); prim_req = 1'b0;
      wait_cmd("t4_cmd_wait");
      command_ready = 1'b1; tick(); command_ready = 1'b0;
      prim_req = 1'b1; tick(); prim_req = 1'b0;
      check("t4_overrun", 32'(status[7:0]), 32'd1);
      response_valid = 1'b1; response_channel = 5'd1; response_data = 12'h555;
      tick(); response_valid = 1'b0;
      check("t4_prim", {19'd0, prim_stb, prim_data}, {19'd0, 1'b1, 12'h555});
      n_cmd = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (command_valid || prim_stb) n_cmd++;
      end
      check("t4_single_delivery", 32'(n_cmd), 32'd0);
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      check("t4_clr", 32'(status[7:0]), 32'd0);

      // Secondary timeout, then primary still serviced
      do_reset();
      in = 32'h0000_0007; in_stb = 1'b1; tick(); in_stb = 1'b0;
      wait_cmd("t5_cmd_wait");
      command_ready = 1'b1; tick(); command_ready = 1'b0;
      guard = 0;
      while (!out_stb && guard < 1100) begin
         tick();
         guard++;
      end
      check("t5_out_stb", 32'(out_stb), 32'd1);
      check("t5_out", out, 32'h8007_0000);
      check("t5_timeouts", 32'(status[15:8]), 32'd1);
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      adc_auto = 1'b1; command_ready = 1'b1; resp_cnt = 0;
      prim_req = 1'b1; tick(); prim_req = 1'b0;
      guard = 0;
      while (!prim_stb && guard < 50) begin
         tick();
         guard++;
      end
      check("t5_prim_after", {19'd0, prim_stb, prim_data}, {19'd0, 1'b1, 12'h111});
      adc_auto = 1'b0; command_ready = 1'b0; response_valid = 1'b0;
      tick(); tick();

      // Channel mismatch discard, then reset mid-conversion
      do_reset();
      prim_req = 1'b1; tick(); prim_req = 1'b0;
      wait_cmd("t6_cmd_wait");
      command_ready = 1'b1; tick(); command_ready = 1'b0;
      response_valid = 1'b1; response_channel = 5'd2; response_data = 12'h222;
      tick(); response_valid = 1'b0;
      check("t6_no_stb_on_mis", 32'(prim_stb), 32'd0);
      check("t6_mismatch", 32'(status[23:16]), 32'd1);
      response_valid = 1'b1; response_channel = 5'd1; response_data = 12'h0AA;
      tick(); response_valid = 1'b0;
      check("t6_prim", {19'd0, prim_stb, prim_data}, {19'd0, 1'b1, 12'h0AA});
      tick(); tick();
      prim_req = 1'b1; tick(); prim_req = 1'b0;
      wait_cmd("t6_cmd_wait2");
      rst = 1'b1; tick(); rst = 1'b0;
      check("t6_rst_cmd", 32'(command_valid), 32'd0);
      check("t6_rst_status", status, 32'd0);
      response_valid = 1'b1; response_channel = 5'd1; response_data = 12'h777;
      tick(); response_valid = 1'b0;
      tick();
      check("t6_late_resp", {31'd0, prim_stb}, 32'd0);
      check("t6_late_status", status, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
